// File: rtl/reg_share_arbiter_pkg.sv
// reg_share_arbiter_pkg
//   Shared definitions for the shared-register write arbiter: FSM state
//   encodings and the default requester count / data width.
package reg_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches req starting at index ptr
//   and walking upward, wrapping from N-1 back to 0, and reports the first
//   set bit.
// Ports:
//   req    in  [N-1:0]   request vector
//   ptr    in  [PW-1:0]  search start index (0..N-1)
//   idx    out [PW-1:0]  winning index (0 when valid is low)
//   onehot out [N-1:0]   one-hot of idx (all zeros when valid is low)
//   valid  out           at least one request is set
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic [N-1:0]  onehot,
  output logic          valid
);

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int off = 0; off < N; off++) begin
      int cand;
      // Explicit wrap so N does not have to be a power of two.
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = PW'(cand);
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
//   Round-robin write arbiter that owns one shared W-bit register. One
//   requester is granted at a time; its data slice is loaded into q and a
//   one-cycle ack is returned. Optional grant locking keeps the grant on
//   one requester for back-to-back writes (macro ARB_LOCK_EN).
//
// Handshake: a requester holds req[i] and wdata slice i stable from
//   assertion until it sees ack[i]. ack[i] is high for exactly one cycle
//   per completed write. A req still high in the ack cycle is arbitrated
//   again at the end of that cycle.
//
// Ports:
//   clk        in             rising-edge clock
//   rst        in             synchronous active-high reset
//   req        in  [N-1:0]    request vector
//   wdata      in  [N*W-1:0]  write data, requester i on [i*W +: W]
//   lock       in  [N-1:0]    grant-lock request (only with ARB_LOCK_EN)
//   gnt        out [N-1:0]    registered one-hot grant or zero
//   ack        out [N-1:0]    registered one-cycle write-done pulse
//   q          out [W-1:0]    shared register contents
//   state_dbg  out [1:0]      current FSM state (arb_state_e encoding)
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   q,
  output logic [1:0]     state_dbg
);

  localparam int PW = $clog2(N);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [W-1:0]  q_q, q_d;

  logic [PW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  logic          pick_valid;

  logic [W-1:0]  win_slice;
  logic [N-1:0]  win_oh;
  logic [PW-1:0] ptr_inc;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .idx    (pick_idx),
    .onehot (pick_onehot),
    .valid  (pick_valid)
  );

  assign win_slice = wdata[win_q*W +: W];
  // Next search start after the current winner, wrapped explicitly.
  assign ptr_inc   = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);

  always_comb begin
    win_oh        = '0;
    win_oh[win_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    q_d     = q_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_WRITE;
          win_d   = pick_idx;
          gnt_d   = pick_onehot;
        end
      end
      ST_WRITE: begin
        // The write always completes, even if req[winner] has dropped.
        q_d   = win_slice;
        ack_d = win_oh;
        ptr_d = ptr_inc;
`ifdef ARB_LOCK_EN
        if (lock[win_q]) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
`else
        state_d = ST_IDLE;
        gnt_d   = '0;
`endif
      end
      ST_LOCKED: begin
`ifdef ARB_LOCK_EN
        if (req[win_q]) begin
          q_d   = win_slice;
          ack_d = win_oh;
        end
        if (!lock[win_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_inc;
        end
`else
        state_d = ST_IDLE;
        gnt_d   = '0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign q         = q_q;
  assign state_dbg = state_q;

endmodule
